stream_arbiter_2to1: RTL and testbench

- Two-input, packet-aware, round-robin stream arbiter with a registered output stage.
- Sits directly upstream of the team's `mux_2to1` datapath.
  - Decides which of two producers owns the output.
  - Drives the select (`sel`, 0 = A, 1 = B).
  - Forwards the winning stream's beats through one pipeline register with valid/ready flow control.
- A grant is held for a whole packet, up to and including the beat flagged `last`.

---
 rtl/stream_arbiter_2to1_if.sv | 11 +
 rtl/stream_arbiter_2to1.sv | 104 ++++++++++
 tb/tb_stream_arbiter_2to1.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stream_arbiter_2to1_if.sv
// One valid/ready stream with a packet delimiter. The arbiter uses it twice as a
// consumer (slave) and once as a producer (master).
interface stream_arbiter_2to1_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             last;
  logic             ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/stream_arbiter_2to1.sv
// Packet-aware round-robin 2:1 stream arbiter. The grant is locked until the
// packet's last beat. Output goes through a single valid/ready register stage.
module stream_arbiter_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  stream_arbiter_2to1_if.slave    a,
  stream_arbiter_2to1_if.slave    b,
  stream_arbiter_2to1_if.master   y,
  output logic                    sel,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t           state, state_nxt;
  logic             prio, prio_nxt;
  logic             sel_q, sel_nxt;
  logic [WIDTH-1:0] y_data_q;
  logic             y_valid_q, y_last_q;
  logic             slot_free;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_last;

  // Ready depends only on state and the output register, never on x_valid.
  assign slot_free = ~y_valid_q | y.ready;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    sel_nxt   = sel_q;
    a.ready   = 1'b0;
    b.ready   = 1'b0;
    load      = 1'b0;
    load_data = a.data;
    load_last = a.last;
    unique case (state)
      IDLE: begin
        if (a.valid && (!b.valid || !prio)) begin
          state_nxt = GRANT_A;
          sel_nxt   = 1'b0;
        end else if (b.valid) begin
          state_nxt = GRANT_B;
          sel_nxt   = 1'b1;
        end
      end
      GRANT_A: begin
        a.ready = slot_free;
        if (a.valid && slot_free) begin
          load = 1'b1;
          if (a.last) begin
            state_nxt = IDLE;
            prio_nxt  = 1'b1;
          end
        end
      end
      GRANT_B: begin
        b.ready   = slot_free;
        load_data = b.data;
        load_last = b.last;
        if (b.valid && slot_free) begin
          load = 1'b1;
          if (b.last) begin
            state_nxt = IDLE;
            prio_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      sel_q     <= 1'b0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      y_data_q  <= '0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      sel_q <= sel_nxt;
      // A same-cycle load wins over the unload, so the slot never bubbles.
      if (load) begin
        y_data_q  <= load_data;
        y_last_q  <= load_last;
        y_valid_q <= 1'b1;
      end else if (y.ready) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign y.data  = y_data_q;
  assign y.valid = y_valid_q;
  assign y.last  = y_last_q;
  assign sel     = sel_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_stream_arbiter_2to1.sv
// Directed bench: a vector table for reset, single packet and contention, then
// hand-written sequences for backpressure, grant lock and mid-packet reset.
module tb_stream_arbiter_2to1;

  logic clk = 1'b0;
  logic rst_n;
  logic sel, busy;

  stream_arbiter_2to1_if #(.WIDTH(8)) a_if ();
  stream_arbiter_2to1_if #(.WIDTH(8)) b_if ();
  stream_arbiter_2to1_if #(.WIDTH(8)) y_if ();

  stream_arbiter_2to1 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a_if),
    .b    (b_if),
    .y    (y_if),
    .sel  (sel),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, av;
    logic [7:0] ad;
    logic       al, bv;
    logic [7:0] bd;
    logic       bl, yr;
    logic       ar, br, yv, yl, sel, busy;
    logic [7:0] yd;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int r, av, ad, al, bv, bd, bl, yr,
                              input int ar, br, yv, yl, s, bz, yd);
    vec_t v;
    v.rst_n = 1'(r);  v.av = 1'(av); v.ad = 8'(ad); v.al = 1'(al);
    v.bv = 1'(bv);    v.bd = 8'(bd); v.bl = 1'(bl); v.yr = 1'(yr);
    v.ar = 1'(ar);    v.br = 1'(br); v.yv = 1'(yv); v.yl = 1'(yl);
    v.sel = 1'(s);    v.busy = 1'(bz); v.yd = 8'(yd);
    return v;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the next rising edge.
  task automatic apply(input int r, av, ad, al, bv, bd, bl, yr);
    @(negedge clk);
    rst_n      = 1'(r);
    a_if.valid = 1'(av); a_if.data = 8'(ad); a_if.last = 1'(al);
    b_if.valid = 1'(bv); b_if.data = 8'(bd); b_if.last = 1'(bl);
    y_if.ready = 1'(yr);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {a_if.ready, b_if.ready, y_if.valid, y_if.last, sel, busy, y_if.data};
  endfunction

  initial begin
    logic [13:0] act, exp, mask;
    rst_n = 1'b0;
    a_if.valid = 1'b0; a_if.data = '0; a_if.last = 1'b0;
    b_if.valid = 1'b0; b_if.data = '0; b_if.last = 1'b0;
    y_if.ready = 1'b1;

    // Fields: rst av ad al bv bd bl yr | ar br yv yl sel busy yd
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,8,0,1,16,0,1, 0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,1, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(1,1, 8,0,0, 0,0,1, 1,0,0,0,0,1, 0));
    vecs.push_back(mk(1,1, 8,0,0, 0,0,1, 1,0,1,0,0,1, 8));
    vecs.push_back(mk(1,1, 9,0,0, 0,0,1, 1,0,1,0,0,1, 9));
    vecs.push_back(mk(1,1,10,1,0, 0,0,1, 0,0,1,1,0,0,10));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,1, 0,0,0,0,0,0, 0));
    vecs.push_back(mk(0,0, 0,0,0, 0,0,1, 0,0,0,0,0,0, 0));
    // Contention, two full A/B rounds of 2-beat packets
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(1,1,8,0,1,16,0,1, 1,0,0,0,0,1, 0));
      vecs.push_back(mk(1,1,8,0,1,16,0,1, 1,0,1,0,0,1, 8));
      vecs.push_back(mk(1,1,8,1,1,16,0,1, 0,0,1,1,0,0, 8));
      vecs.push_back(mk(1,1,8,0,1,16,0,1, 0,1,0,0,1,1, 0));
      vecs.push_back(mk(1,1,8,0,1,16,0,1, 0,1,1,0,1,1,16));
      vecs.push_back(mk(1,1,8,0,1,16,1,1, 0,0,1,1,1,0,16));
    end
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 0,0,0,0,1,0,0));

    foreach (vecs[i]) begin
      apply(vecs[i].rst_n, vecs[i].av, vecs[i].ad, vecs[i].al,
            vecs[i].bv, vecs[i].bd, vecs[i].bl, vecs[i].yr);
      act  = outs();
      exp  = {vecs[i].ar, vecs[i].br, vecs[i].yv, vecs[i].yl, vecs[i].sel, vecs[i].busy, vecs[i].yd};
      // Payload is only meaningful while valid, except right after reset.
      mask = (vecs[i].rst_n && !vecs[i].yv) ? 14'h3B00 : 14'h3FFF;
      n_chk++;
      if (((act ^ exp) & mask) != 0) begin
        n_fail++;
        $display("FAIL vec%0d: got {ar,br,yv,yl,sel,busy,yd}=0x%0h, expected 0x%0h (mask 0x%0h)",
                 i, act, exp, mask);
      end
    end

    // Backpressure on a B packet
    apply(0,0,0,0,0,0,0,1);
    apply(1,0,0,0,1,16,0,1);
    chk("bp_grant_sel", sel, 1);
    chk("bp_grant_brdy", b_if.ready, 1);
    apply(1,0,0,0,1,16,0,1);
    chk("bp_beat16", {y_if.valid, y_if.data}, {1'b1, 8'd16});
    for (int k = 0; k < 4; k++) begin
      apply(1,0,0,0,1,17,0,0);
      chk("bp_stall_data", {y_if.valid, y_if.data}, {1'b1, 8'd16});
      chk("bp_stall_brdy", b_if.ready, 0);
    end
    apply(1,0,0,0,1,17,0,1);
    chk("bp_beat17", {y_if.valid, y_if.last, y_if.data}, {2'b10, 8'd17});
    apply(1,0,0,0,1,18,1,1);
    chk("bp_beat18", {y_if.valid, y_if.last, y_if.data}, {2'b11, 8'd18});
    chk("bp_busy_drop", busy, 0);
    apply(1,0,0,0,0,0,0,1);
    chk("bp_drain", y_if.valid, 0);

    // Grant lock: A stalls mid-packet while B waits
    apply(1,1,8,0,0,0,0,1);
    chk("lock_grant_a", {sel, a_if.ready}, 2'b01);
    apply(1,1,8,0,0,0,0,1);
    chk("lock_beat8", {y_if.valid, y_if.data}, {1'b1, 8'd8});
    for (int k = 0; k < 3; k++) begin
      apply(1,0,0,0,1,16,0,1);
      chk("lock_hold", {sel, b_if.ready, busy}, 3'b001);
    end
    apply(1,1,9,1,1,16,0,1);
    chk("lock_last", {y_if.valid, y_if.last, y_if.data}, {2'b11, 8'd9});
    chk("lock_release", {busy, b_if.ready}, 2'b00);
    apply(1,0,0,0,1,16,0,1);
    chk("lock_grant_b", {sel, b_if.ready, busy}, 3'b111);
    apply(1,0,0,0,1,16,1,1);
    chk("lock_b_beat", {y_if.valid, y_if.last, y_if.data}, {2'b11, 8'd16});

    // Single-beat A packet leaves prio on B, then reset interrupts a B packet
    apply(1,1,5,1,0,0,0,1);
    chk("sb_grant", {a_if.ready, busy, sel}, 3'b110);
    apply(1,1,5,1,0,0,0,1);
    chk("sb_beat", {y_if.valid, y_if.last, y_if.data, busy}, {2'b11, 8'd5, 1'b0});
    apply(1,0,0,0,1,1,0,1);
    chk("rm_grant_b", sel, 1);
    apply(1,0,0,0,1,1,0,1);
    apply(1,0,0,0,1,2,0,1);
    chk("rm_beat2", {y_if.valid, y_if.data}, {1'b1, 8'd2});
    apply(0,0,0,0,1,3,0,1);
    chk("rm_reset", {y_if.valid, busy, sel, b_if.ready, a_if.ready}, 5'b0);
    apply(1,1,8,0,1,16,0,1);
    chk("rm_a_first", {sel, a_if.ready, b_if.ready, busy}, 4'b0101);
    apply(1,1,8,1,1,16,0,1);
    chk("rm_a_beat", {y_if.valid, y_if.last, y_if.data}, {2'b11, 8'd8});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
